// File: rtl/sync_fifo_dw_prog_if.sv
// Bus bundle for sync_fifo_dw_prog: write side, read side, thresholds and status.
// With SYNC_FIFO_DW_PROG_ERR_EN defined it also carries the overflow/underflow pulses.
interface sync_fifo_dw_prog_if #(
    parameter int DIN_WIDTH   = 8,
    parameter int DOUT_WIDTH  = 4,
    parameter int WADDR_WIDTH = 4
);
    localparam int RADDR_WIDTH = $clog2(((2 ** WADDR_WIDTH) * DIN_WIDTH) / DOUT_WIDTH);

    logic [DIN_WIDTH-1:0]   din;
    logic                   wr_en;
    logic                   full;
    logic                   almost_full;
    logic [WADDR_WIDTH:0]   prog_full_thresh;
    logic [WADDR_WIDTH:0]   wr_data_count;
    logic [DOUT_WIDTH-1:0]  dout;
    logic                   rd_en;
    logic                   valid;
    logic                   empty;
    logic                   almost_empty;
    logic [RADDR_WIDTH:0]   prog_empty_thresh;
    logic [RADDR_WIDTH:0]   rd_data_count;
`ifdef SYNC_FIFO_DW_PROG_ERR_EN
    logic                   overflow;
    logic                   underflow;

    modport master (
        output din, wr_en, prog_full_thresh, rd_en, prog_empty_thresh,
        input  full, almost_full, wr_data_count, dout, valid, empty,
               almost_empty, rd_data_count, overflow, underflow
    );
    modport slave (
        input  din, wr_en, prog_full_thresh, rd_en, prog_empty_thresh,
        output full, almost_full, wr_data_count, dout, valid, empty,
               almost_empty, rd_data_count, overflow, underflow
    );
`else
    modport master (
        output din, wr_en, prog_full_thresh, rd_en, prog_empty_thresh,
        input  full, almost_full, wr_data_count, dout, valid, empty,
               almost_empty, rd_data_count
    );
    modport slave (
        input  din, wr_en, prog_full_thresh, rd_en, prog_empty_thresh,
        output full, almost_full, wr_data_count, dout, valid, empty,
               almost_empty, rd_data_count
    );
`endif
endinterface

// File: rtl/sync_fifo_dw_prog.sv
// Single-clock width-converting FIFO with programmable almost flags, data counts and FWFT/standard read.
// Optional macro SYNC_FIFO_DW_PROG_ERR_EN adds registered overflow/underflow pulses.
module sync_fifo_dw_prog #(
    parameter int DIN_WIDTH   = 8,
    parameter int DOUT_WIDTH  = 4,
    parameter int WADDR_WIDTH = 4,
    parameter int FWFT_EN     = 1,
    parameter int MSB_FIFO    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sync_fifo_dw_prog_if.slave   bus
);
    localparam int NW          = (DIN_WIDTH < DOUT_WIDTH) ? DIN_WIDTH : DOUT_WIDTH;
    localparam int WU          = DIN_WIDTH / NW;
    localparam int RU          = DOUT_WIDTH / NW;
    localparam int UNITS       = (2 ** WADDR_WIDTH) * WU;
    localparam int UADDR       = $clog2(UNITS);
    localparam int WSH         = $clog2(WU);
    localparam int RSH         = $clog2(RU);
    localparam int RADDR_WIDTH = UADDR - RSH;

    localparam logic [UADDR:0] L_UNITS = (UADDR+1)'(UNITS);
    localparam logic [UADDR:0] L_WU    = (UADDR+1)'(WU);
    localparam logic [UADDR:0] L_RU    = (UADDR+1)'(RU);

    logic [NW-1:0]          r_mem [UNITS];
    logic [UADDR-1:0]       r_wptr;
    logic [UADDR-1:0]       r_rptr;
    logic [UADDR:0]         r_occ;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_af;
    logic                   r_ae;
    logic [WADDR_WIDTH:0]   r_wcnt;
    logic [RADDR_WIDTH:0]   r_rcnt;

    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic [UADDR:0]         w_occ_nxt;
    logic [UADDR:0]         w_free_nxt;
    logic [WADDR_WIDTH:0]   w_wcnt_nxt;
    logic [RADDR_WIDTH:0]   w_rcnt_nxt;
    logic [DOUT_WIDTH-1:0]  w_rdata;

    // Accept decisions use the pre-edge flags, so a write into an empty FIFO is never readable the same cycle.
    always_comb begin
        w_wr_acc = bus.wr_en && !r_full;
        w_rd_acc = bus.rd_en && !r_empty;
    end

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_wr_acc) w_occ_nxt = w_occ_nxt + L_WU;
        if (w_rd_acc) w_occ_nxt = w_occ_nxt - L_RU;
    end

    always_comb begin
        w_free_nxt = L_UNITS - w_occ_nxt;
        w_wcnt_nxt = w_occ_nxt[UADDR:WSH];
        w_rcnt_nxt = w_occ_nxt[UADDR:RSH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= (bus.prog_full_thresh == '0);
            r_ae    <= 1'b1;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + UADDR'(WU);
            if (w_rd_acc) r_rptr <= r_rptr + UADDR'(RU);
            r_occ   <= w_occ_nxt;
            r_full  <= (w_free_nxt < L_WU);
            r_empty <= (w_occ_nxt < L_RU);
            r_wcnt  <= w_wcnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_af    <= (w_wcnt_nxt >= bus.prog_full_thresh);
            r_ae    <= (w_rcnt_nxt <= bus.prog_empty_thresh);
        end
    end

    // Storage is unit-addressed; a wide write fills WU consecutive units in slice order.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int unsigned i = 0; i < WU; i++) begin
                if (MSB_FIFO != 0)
                    r_mem[r_wptr + UADDR'(i)] <= bus.din[DIN_WIDTH-1-i*NW -: NW];
                else
                    r_mem[r_wptr + UADDR'(i)] <= bus.din[i*NW +: NW];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int unsigned j = 0; j < RU; j++) begin
            if (MSB_FIFO != 0)
                w_rdata[DOUT_WIDTH-1-j*NW -: NW] = r_mem[r_rptr + UADDR'(j)];
            else
                w_rdata[j*NW +: NW] = r_mem[r_rptr + UADDR'(j)];
        end
    end

    generate
        if (FWFT_EN != 0) begin : g_fwft
            // Gated to zero while empty so dout is defined from reset onward.
            assign bus.dout  = r_empty ? '0 : w_rdata;
            assign bus.valid = !r_empty;
        end else begin : g_std
            logic [DOUT_WIDTH-1:0] r_dout;
            logic                  r_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_rd_acc;
                    if (w_rd_acc) r_dout <= w_rdata;
                end
            end

            assign bus.dout  = r_dout;
            assign bus.valid = r_valid;
        end
    endgenerate

    assign bus.full          = r_full;
    assign bus.empty         = r_empty;
    assign bus.almost_full   = r_af;
    assign bus.almost_empty  = r_ae;
    assign bus.wr_data_count = r_wcnt;
    assign bus.rd_data_count = r_rcnt;

`ifdef SYNC_FIFO_DW_PROG_ERR_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= bus.wr_en && r_full;
            r_udf <= bus.rd_en && r_empty;
        end
    end

    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_udf;
`endif
endmodule

// File: doc/sync_fifo_dw_prog.md
Name: sync_fifo_dw_prog

Overview:
- Single-clock FIFO with independent write and read widths.
- Either side may be the wider one; the ratio between widths is a power of two (1, 2, 4, 8, ...).
- Adds programmable almost-full/almost-empty thresholds, per-side data counts and selectable FWFT/standard read mode.
- Used as the general-purpose width-converting buffer between stream stages in the sync FIFO library.

Parameters:
- DIN_WIDTH, 8, write word width; max(DIN_WIDTH,DOUT_WIDTH)/min(DIN_WIDTH,DOUT_WIDTH) is a power of two.
- DOUT_WIDTH, 4, read word width.
- WADDR_WIDTH, 4, write depth = 2^WADDR_WIDTH din words; total capacity CAP = 2^WADDR_WIDTH*DIN_WIDTH bits.
- FWFT_EN, 1, 1 = first-word fall-through; 0 = standard read with 1-cycle latency.
- MSB_FIFO, 1, 1 = high-order slice is first in/out when splitting or packing; 0 = low-order slice first.
- (derived) NW = min width, WU = DIN_WIDTH/NW, RU = DOUT_WIDTH/NW, UNITS = CAP/NW, RADDR_WIDTH = log2(CAP/DOUT_WIDTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DIN_WIDTH  write data.
- wr_en  in  1  write request.
- full  out  1  fewer than WU free units.
- almost_full  out  1  wr_data_count >= prog_full_thresh.
- prog_full_thresh  in  WADDR_WIDTH+1  threshold in din words.
- wr_data_count  out  WADDR_WIDTH+1  stored data in whole din words (floor).
- dout  out  DOUT_WIDTH  read data.
- rd_en  in  1  read request / pop.
- valid  out  1  dout holds newly read word (standard mode); equals !empty in FWFT.
- empty  out  1  fewer than RU stored units.
- almost_empty  out  1  rd_data_count <= prog_empty_thresh.
- prog_empty_thresh  in  RADDR_WIDTH+1  threshold in dout words.
- rd_data_count  out  RADDR_WIDTH+1  stored data in whole dout words (floor).

Behaviour:
- Storage and occupancy are tracked in NW-bit units; occ counter is log2(UNITS)+1 bits; write/read pointers wrap modulo UNITS.
- Write is accepted when wr_en && !full, sampled before the edge: occ += WU.
- Read is accepted when rd_en && !empty: occ -= RU.
- Simultaneous accepted write and read: occ += WU - RU in one cycle.
- Write while full is dropped and memory is unchanged. Read while empty is ignored; dout and pointers hold.
- No write-through: empty is evaluated on pre-edge occ, so a write into an empty FIFO is not readable in the same cycle.
- full, empty, almost_full, almost_empty and both counts are registered and reflect occ after the edge.
  - Write-to-empty-deassert latency: 1 cycle.
  - Read-to-full-deassert latency: 1 cycle.
- Thresholds are compared every cycle against the registered counts. Changing a threshold takes effect on the next edge.
- MSB_FIFO=1:
  - Wide din splits high slice first.
  - Narrow writes pack into dout from the MSB downward; the first written word lands in dout[DOUT_WIDTH-1 -: NW].
- MSB_FIFO=0: mirror image of the above (low slice first, pack from the LSB upward).
- FWFT_EN=1: dout shows the word at the read pointer whenever !empty; rd_en advances it; valid = !empty.
- FWFT_EN=0: dout is registered and updated on the edge that accepts rd_en; valid is a 1-cycle pulse in the next cycle; dout holds otherwise.
- Reset (asynchronous, any time, including mid-burst): pointers=0, occ=0, full=0, almost_full=(0>=prog_full_thresh), empty=1, almost_empty=1, counts=0, dout=0, valid=0. Memory contents are not cleared.

Optional Feature:
- Macro SYNC_FIFO_DW_PROG_ERR_EN.
- Defined: adds ports overflow (out, 1) and underflow (out, 1).
  - overflow is a registered 1-cycle pulse the cycle after wr_en && full.
  - underflow is a registered 1-cycle pulse the cycle after rd_en && empty.
  - Both reset to 0.
- Undefined: these ports and their logic are absent. Dropped requests remain silent.

Test Plan:
- 8->4, MSB_FIFO=1, FWFT=1: write 0xA5 -> next cycle empty=0, dout=0xA; rd_en -> dout=0x5; rd_en -> empty=1, rd_data_count=0.
- 8->4, WADDR_WIDTH=4: 16 writes, no reads -> full=1 after 16th, wr_data_count=16, rd_data_count=32; 17th write dropped; overflow pulses when macro is defined.
- 4->16, MSB_FIFO=0, FWFT=0: write 1,2,3,4 -> empty=0 only after 4th; rd_en -> next cycle valid=1, dout=0x4321.
- Thresholds: prog_full_thresh=3, prog_empty_thresh=1 -> almost_full rises on 3rd write; almost_empty falls when rd_data_count=2.
- Simultaneous wr_en/rd_en at full (8->8) -> read accepted, write dropped, full=0 next cycle. At empty -> write accepted, read ignored, underflow pulses.
- Assert rst_n low mid-burst with 5 words stored -> all flags and counts return to reset values immediately; new writes after release read back correctly from pointer 0.
